// File: rtl/simpleio_pkg.sv
// Shared constants for the simple-I/O path: pin counts, released (reset)
// levels of the board inputs and the default debounce timing.
package simpleio_pkg;

  localparam int N_SW  = 4;
  localparam int N_KEY = 4;

  // Released levels: switches idle low, push-buttons idle high (active-low).
  localparam logic [N_SW-1:0]  SW_RST_LEVEL  = 4'b0000;
  localparam logic [N_KEY-1:0] KEY_RST_LEVEL = 4'b1111;

  // 1 ms sample tick at 50 MHz, four agreeing ticks to accept a level.
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_TICK_W       = 16;
  localparam int DEF_STAB_W       = 3;

endpackage : simpleio_pkg

// File: rtl/input_debouncer_debounce_bit.sv
// debounce_bit: one raw asynchronous input -> two-flop synchroniser ->
// tick-sampled stability counter -> registered stable level.
// RST_VAL is the released level loaded into every flop on reset so that a
// reset never produces a spurious edge on the clean output.
module debounce_bit #(
  parameter logic RST_VAL      = 1'b0,
  parameter int   STABLE_TICKS = 4,
  parameter int   STAB_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam logic [STAB_W-1:0] CNT_LAST = STAB_W'(STABLE_TICKS - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              stable_q, stable_d;
  logic [STAB_W-1:0] cnt_q, cnt_d;

  // Next-state: shift the synchroniser, update counter/level on ticks only.
  always_comb begin
    // NOTE: every variable gets a default before the branches so no path
    // leaves it unassigned and no latch is inferred.
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset to the released level.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the values from
    // before this edge, independent of statement order.
    if (rst) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule : debounce_bit

// File: rtl/input_debouncer.sv
// input_debouncer: synchronises and debounces 4 board switches and 4
// active-low push-buttons for the simple-I/O register block. Raw polarity
// is kept; the I/O block does its own inversion.
// Optional feature macro: INPUT_DEBOUNCER_EVENT_EN -- sticky key-press
// latches (key_evt) and a registered press interrupt (irq). Without it,
// key_evt/irq are tied low and key_ien/key_ack are ignored.
// Parameter limits: TICK_DIV >= 2, STABLE_TICKS >= 1,
// 2**TICK_W >= TICK_DIV, 2**STAB_W >= STABLE_TICKS.
module input_debouncer
  import simpleio_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int TICK_W       = DEF_TICK_W,
  parameter int STAB_W       = DEF_STAB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_raw,
  output logic [N_SW-1:0]  switches,
  output logic [N_KEY-1:0] keys,
  input  logic [N_KEY-1:0] key_ien,
  input  logic [N_KEY-1:0] key_ack,
  output logic [N_KEY-1:0] key_evt,
  output logic             irq
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [N_SW-1:0]   sw_stable;
  logic [N_KEY-1:0]  key_stable;

  // Free-running sample divider shared by all bits; tick marks the last count.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .RST_VAL      (SW_RST_LEVEL[i]),
      .STABLE_TICKS (STABLE_TICKS),
      .STAB_W       (STAB_W)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i])
    );
  end

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .RST_VAL      (KEY_RST_LEVEL[i]),
      .STABLE_TICKS (STABLE_TICKS),
      .STAB_W       (STAB_W)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .raw    (key_raw[i]),
      .stable (key_stable[i])
    );
  end

  assign switches = sw_stable;
  assign keys     = key_stable;

`ifdef INPUT_DEBOUNCER_EVENT_EN
  logic [N_KEY-1:0] keys_prev_q, keys_prev_d;
  logic [N_KEY-1:0] key_evt_q, key_evt_d;
  logic             irq_q, irq_d;
  logic [N_KEY-1:0] key_press;

  // Press = stable key fell 1->0 last cycle; a press beats a same-cycle ack.
  always_comb begin
    keys_prev_d = key_stable;
    key_press   = keys_prev_q & ~key_stable;
    key_evt_d   = (key_evt_q & ~key_ack) | key_press;
    irq_d       = |(key_evt_d & key_ien);
  end

  // Event latches and interrupt; irq is built from the next latch value so
  // it moves in the same cycle as key_evt.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_prev_q <= KEY_RST_LEVEL;
      key_evt_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      keys_prev_q <= keys_prev_d;
      key_evt_q   <= key_evt_d;
      irq_q       <= irq_d;
    end
  end

  assign key_evt = key_evt_q;
  assign irq     = irq_q;
`else
  // Feature absent: ports stay so the top level is unchanged.
  logic unused_evt_inputs;
  assign unused_evt_inputs = ^{key_ien, key_ack};
  assign key_evt = '0;
  assign irq     = 1'b0;
`endif

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with TICK_DIV=4, STABLE_TICKS=3.
// Expectations for key_evt/irq follow INPUT_DEBOUNCER_EVENT_EN.
module tb_input_debouncer;

  localparam int TD = 4;
  localparam int ST = 3;
`ifdef INPUT_DEBOUNCER_EVENT_EN
  localparam logic EVT = 1'b1;
`else
  localparam logic EVT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_raw  = 4'b0000;
  logic [3:0] key_raw = 4'b1111;
  logic [3:0] key_ien = 4'b0000;
  logic [3:0] key_ack = 4'b0000;
  logic [3:0] switches, keys, key_evt;
  logic       irq;

  int errors = 0;
  int checks = 0;

  input_debouncer #(
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .TICK_W       (16),
    .STAB_W       (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .key_raw  (key_raw),
    .switches (switches),
    .keys     (keys),
    .key_ien  (key_ien),
    .key_ack  (key_ack),
    .key_evt  (key_evt),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] sv, input logic [3:0] kv);
    rst = 1'b1; sw_raw = sv; key_raw = kv; key_ack = 4'b0000;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Wait (bounded) for keys[0] to reach lvl; timeout is a failed check.
  task automatic wait_key0(input logic lvl, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      if (keys[0] === lvl) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: keys[0]=%b never reached %b within 20 clk", name, keys[0], lvl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_raw = 4'b1010; key_raw = 4'b0101; key_ien = 4'hF; key_ack = 4'h0;
    repeat (3) begin
      step();
      checks++;
      if ({switches, keys, key_evt, irq} !== 13'b0000_1111_0000_0) begin
        errors++;
        $display("FAIL reset_values: got sw=%b keys=%b evt=%b irq=%b want 0000/1111/0000/0",
                 switches, keys, key_evt, irq);
      end
    end
    rst = 1'b0; sw_raw = 4'b0000; key_raw = 4'b1111; key_ien = 4'h0;
    repeat (2 * TD) begin
      step();
      checks++;
      if ({switches, keys, key_evt, irq} !== 13'b0000_1111_0000_0) begin
        errors++;
        $display("FAIL reset_hold: got sw=%b keys=%b evt=%b irq=%b want 0000/1111/0000/0",
                 switches, keys, key_evt, irq);
      end
    end
  endtask

  task automatic test_clean_step();
    int lat = 0;
    do_reset(4'b0000, 4'b1111);
    sw_raw[2] = 1'b1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step();
      if (switches[2] === 1'b1) lat = c;
    end
    checks++;
    if (lat < 2 + 2 * TD || lat > 2 + 3 * TD) begin
      errors++;
      $display("FAIL step_latency: rise after %0d clk, want %0d..%0d", lat, 2 + 2 * TD, 2 + 3 * TD);
    end
    repeat (6) step();
    checks++;
    if ({switches, keys} !== 8'b0100_1111) begin
      errors++;
      $display("FAIL step_others: got sw=%b keys=%b want 0100/1111", switches, keys);
    end
  endtask

  task automatic test_glitch();
    int fall_at = 0;
    int rise_lat = 0;
    do_reset(4'b0000, 4'b1111);
    key_raw[1] = 1'b0;
    repeat (6) begin
      step();
      checks++;
      if (keys !== 4'b1111) begin
        errors++;
        $display("FAIL glitch_short: keys=%b want 1111", keys);
      end
    end
    key_raw[1] = 1'b1;
    repeat (30) begin
      step();
      checks++;
      if (keys !== 4'b1111) begin
        errors++;
        $display("FAIL glitch_after: keys=%b want 1111", keys);
      end
    end
    key_raw[1] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (fall_at == 0 && keys === 4'b1101) fall_at = c;
    end
    key_raw[1] = 1'b1;
    checks++;
    if (fall_at < 2 + 2 * TD || fall_at > 2 + 3 * TD) begin
      errors++;
      $display("FAIL long_pulse_fall: fall after %0d clk, want %0d..%0d", fall_at, 2 + 2 * TD, 2 + 3 * TD);
    end
    for (int c = 1; c <= 30 && rise_lat == 0; c++) begin
      step();
      if (keys === 4'b1111) rise_lat = c;
    end
    checks++;
    if (rise_lat < 2 + 2 * TD || rise_lat > 2 + 3 * TD) begin
      errors++;
      $display("FAIL long_pulse_rise: rise after %0d clk, want %0d..%0d", rise_lat, 2 + 2 * TD, 2 + 3 * TD);
    end
  endtask

  task automatic test_bounce();
    logic prev;
    int   trans = 0;
    do_reset(4'b0000, 4'b1111);
    prev = switches[0];
    for (int i = 0; i < 40; i++) begin
      sw_raw[0] = (((i / 3) % 2) == 0);
      step();
      if (switches[0] !== prev) begin trans++; prev = switches[0]; end
    end
    checks++;
    if (trans != 0) begin
      errors++;
      $display("FAIL bounce_during: %0d output flips while bouncing, want 0", trans);
    end
    sw_raw[0] = 1'b1;
    repeat (20) begin
      step();
      if (switches[0] !== prev) begin trans++; prev = switches[0]; end
    end
    checks++;
    if (trans != 1 || switches !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_settle: flips=%0d sw=%b, want 1 flip and 0001", trans, switches);
    end
  endtask

  task automatic test_event();
    do_reset(4'b0000, 4'b1111);
    key_ien = 4'b0001;
    key_raw[0] = 1'b0;
    wait_key0(1'b0, "evt_press1_wait");
    checks++;
    if ({key_evt, irq} !== 5'b0000_0) begin
      errors++;
      $display("FAIL evt_early: evt=%b irq=%b want 0000/0 in the fall cycle", key_evt, irq);
    end
    step();
    checks++;
    if ({key_evt, irq} !== {3'b000, EVT, EVT}) begin
      errors++;
      $display("FAIL evt_set: evt=%b irq=%b want %b/%b", key_evt, irq, {3'b000, EVT}, EVT);
    end
    key_ack = 4'b0001;
    step();
    key_ack = 4'b0000;
    checks++;
    if ({key_evt, irq} !== 5'b0000_0) begin
      errors++;
      $display("FAIL evt_ack: evt=%b irq=%b want 0000/0", key_evt, irq);
    end
    key_raw[0] = 1'b1;
    wait_key0(1'b1, "evt_release1_wait");
    step();
    checks++;
    if ({key_evt, irq} !== 5'b0000_0) begin
      errors++;
      $display("FAIL evt_release: evt=%b irq=%b want 0000/0", key_evt, irq);
    end
    key_raw[0] = 1'b0;
    wait_key0(1'b0, "evt_press2_wait");
    step();
    key_raw[0] = 1'b1;
    wait_key0(1'b1, "evt_release2_wait");
    step();
    checks++;
    if ({key_evt, irq} !== {3'b000, EVT, EVT}) begin
      errors++;
      $display("FAIL evt_sticky: evt=%b irq=%b want %b/%b", key_evt, irq, {3'b000, EVT}, EVT);
    end
    key_raw[0] = 1'b0;
    wait_key0(1'b0, "evt_press3_wait");
    key_ack = 4'b0001;
    step();
    key_ack = 4'b0000;
    checks++;
    if ({key_evt, irq} !== {3'b000, EVT, EVT}) begin
      errors++;
      $display("FAIL evt_set_wins: evt=%b irq=%b want %b/%b", key_evt, irq, {3'b000, EVT}, EVT);
    end
    key_ien = 4'b0000;
    step();
    checks++;
    if ({key_evt, irq} !== {3'b000, EVT, 1'b0}) begin
      errors++;
      $display("FAIL evt_ien_mask: evt=%b irq=%b want %b/0", key_evt, irq, {3'b000, EVT});
    end
    key_ack = 4'b0001;
    step();
    key_ack = 4'b0000;
    key_raw[0] = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset(4'b0000, 4'b1111);
    sw_raw[3] = 1'b1;
    repeat (2 * TD) step();
    checks++;
    if (switches[3] !== 1'b0) begin
      errors++;
      $display("FAIL mid_before: switches[3]=%b want 0 after 2 ticks", switches[3]);
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (ST * TD - 1) step();
    checks++;
    if (switches[3] !== 1'b0) begin
      errors++;
      $display("FAIL mid_recount: switches[3]=%b want 0 one clk before full recount", switches[3]);
    end
    step();
    checks++;
    if (switches[3] !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept: switches[3]=%b want 1 after full recount", switches[3]);
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_event();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_input_debouncer

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Sits directly upstream of the onboard simple-I/O register block.
- Takes the raw asynchronous board switches (4) and push-buttons (4), synchronises and debounces them, and drives the clean `switches`/`keys` inputs of the I/O block.
- Raw polarity is preserved: switches are active-high, keys are active-low. The I/O block does its own inversion.
- Optionally latches key-press events and raises an interrupt request.

Parameters:
- TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); minimum 2.
- STABLE_TICKS, 4, consecutive disagreeing samples needed to accept a new level; minimum 1.
- TICK_W, 16, width of the tick divider counter; must satisfy 2^TICK_W >= TICK_DIV.
- STAB_W, 3, width of the per-bit stability counter; must satisfy 2^STAB_W >= STABLE_TICKS.

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- sw_raw  in  4  raw board switches, asynchronous.
- key_raw  in  4  raw board buttons, asynchronous, active-low.
- switches  out  4  debounced switches, registered.
- keys  out  4  debounced keys, registered, active-low.
- key_ien  in  4  per-key press-interrupt enable.
- key_ack  in  4  per-key one-cycle clear of the press latch.
- key_evt  out  4  sticky key-press latch.
- irq  out  1  press interrupt: |(key_evt & key_ien).

Behaviour:
- Reset (rst=1 on a clk edge):
  - Synchroniser flops and stable registers load released levels: switches=4'b0000, keys=4'b1111.
  - Tick counter=0, all stability counters=0, key_evt=0, irq=0.
  - Reset mid-debounce discards any partial count.
- Synchroniser: two flops per bit, 8 bits total (sw_raw then key_raw). Compare value = second flop.
- Tick divider:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` is a one-cycle pulse in the cycle the counter equals TICK_DIV-1.
  - The divider is free-running and shared by all bits.
- Per-bit update, evaluated only when tick=1:
  - sync == stable: cnt <= 0.
  - else if cnt == STABLE_TICKS-1: stable <= sync, cnt <= 0.
  - else: cnt <= cnt+1.
  - Net effect: a level is accepted after STABLE_TICKS consecutive ticks that disagree with the current stable value. Any agreeing tick restarts the count.
- Latency: a clean step on a raw pin reaches the output after 2 clk (sync) + up to TICK_DIV clk (tick phase) + (STABLE_TICKS-1)*TICK_DIV clk.
- Outputs change only on tick cycles; at most one transition per bit per tick.
- A glitch seen on fewer than STABLE_TICKS consecutive ticks never reaches the outputs.
- Bits are fully independent; simultaneous changes on several bits are each handled by their own counter.

Optional Feature:
- Macro: INPUT_DEBOUNCER_EVENT_EN.
- Defined:
  - key_evt[i] sets in the cycle after stable key i goes 1->0 (press).
  - key_evt[i] clears on key_ack[i]=1.
  - If set and ack occur in the same cycle, set wins.
  - Release (0->1) does not set the latch.
  - irq is registered: irq <= |(next key_evt & key_ien), so it follows key_evt with no extra delay.
- Undefined:
  - key_evt and irq are tied to 0.
  - key_ien and key_ack are ignored.
  - The ports remain present so the top level does not change.

Decomposition:
- Shared package (simpleio_pkg):
  - N_SW=4, N_KEY=4.
  - SW_RST_LEVEL=4'b0000, KEY_RST_LEVEL=4'b1111.
  - Default TICK_DIV and STABLE_TICKS constants.
- Natural sub-module: debounce_bit. It contains the 2-flop synchroniser, the stability counter, the stable register and a 1-bit reset-value parameter. It is instantiated 8 times, fed by the one shared tick from the parent.
- The parent holds the tick divider and the event/irq logic.

Test Plan:
Bench runs with TICK_DIV=4, STABLE_TICKS=3.
1. Reset values: assert rst for 3 cycles with raw pins at arbitrary values -> switches=0000, keys=1111, key_evt=0, irq=0. Outputs hold for 2 ticks after release while raw matches the reset levels.
2. Clean step: sw_raw[2] 0->1 held -> switches[2]=1 appears no earlier than 2+8 and no later than 2+12 clk after the edge. Other bits stay unchanged.
3. Glitch reject: key_raw[1] pulled low for 6 clk (at most 2 ticks), then high -> keys stays 1111 indefinitely. A 20 clk low pulse -> keys[1]=0, then returns to 1 after release plus the debounce delay.
4. Bounce: sw_raw[0] toggles every 3 clk for 40 clk, then settles at 1 -> switches[0] shows at most one final 0->1 transition after settling, with no intermediate flips.
5. Event (INPUT_DEBOUNCER_EVENT_EN defined): key_ien=0001, press key 0:
   - key_evt=0001 and irq=1 one cycle after keys[0] falls.
   - key_ack=0001 for one cycle -> key_evt=0, irq=0.
   - A new press arriving in the same cycle as an ack leaves key_evt=1.
   - Built without the macro: key_evt=0 and irq=0 throughout.
6. Reset mid-debounce: start a step, assert rst after 2 ticks, deassert with the raw pin still changed -> the full STABLE_TICKS count is required again from zero.
